// File: rtl/chirp_phase_gen_pkg.sv
// ---------------------------------------------------------------------------
// chirp_phase_gen_pkg : shared widths, chirp type codes and FSM encoding
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package chirp_phase_gen_pkg;

   localparam int PRECISION        = 32;
   localparam int SYMBOL_PRECISION = 16;
   localparam int CHIRP_TYPE_SIZE  = 1;

   localparam logic [CHIRP_TYPE_SIZE-1:0] TYPE_UPCHIRP   = 1'b0;
   localparam logic [CHIRP_TYPE_SIZE-1:0] TYPE_DOWNCHIRP = 1'b1;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

endpackage

`default_nettype wire

// File: rtl/chirp_phase_gen_if.sv
// ---------------------------------------------------------------------------
// chirp_phase_gen_if : chirp descriptor valid/ready bus
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface chirp_phase_gen_if
   import chirp_phase_gen_pkg::*;
#(
   parameter int PREC  = PRECISION,
   parameter int CNT_W = SYMBOL_PRECISION
);
   logic                       chirp_valid;
   logic                       chirp_ready;
   logic [CHIRP_TYPE_SIZE-1:0] chirp_type;
   logic signed [PREC-1:0]     freq_init;
   logic [PREC-1:0]            freq_step;
   logic [PREC-1:0]            freq_max;
   logic [CNT_W-1:0]           chirp_len;

   modport master (
      output chirp_valid, chirp_type, freq_init, freq_step, freq_max, chirp_len,
      input  chirp_ready
   );

   modport slave (
      input  chirp_valid, chirp_type, freq_init, freq_step, freq_max, chirp_len,
      output chirp_ready
   );
endinterface

`default_nettype wire

// File: rtl/chirp_phase_gen_freq_wrap.sv
// ---------------------------------------------------------------------------
// chirp_freq_wrap : next instantaneous frequency with wrap at +/- band edge
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module chirp_freq_wrap
   import chirp_phase_gen_pkg::*;
#(
   parameter int PREC = PRECISION
) (
   input  logic [CHIRP_TYPE_SIZE-1:0] chirp_type,
   input  logic signed [PREC-1:0]     freq,
   input  logic [PREC-1:0]            freq_step,
   input  logic [PREC-1:0]            freq_max,
   output logic signed [PREC-1:0]     freq_next
);
   localparam int W = PREC + 2;

   // Two guard bits keep freq +/- step and the 2*max correction exact.
   logic signed [W-1:0] freq_ext;
   logic signed [W-1:0] step_ext;
   logic signed [W-1:0] max_ext;
   logic signed [W-1:0] sum;
   logic signed [W-1:0] wrapped;

   always_comb begin
      freq_ext = {{2{freq[PREC-1]}}, freq};
      step_ext = {2'b00, freq_step};
      max_ext  = {2'b00, freq_max};
      sum      = freq_ext;
      wrapped  = freq_ext;
      if (chirp_type == TYPE_UPCHIRP) begin
         sum     = freq_ext + step_ext;
         wrapped = (sum > max_ext) ? (sum - (max_ext <<< 1)) : sum;
      end else begin
         sum     = freq_ext - step_ext;
         wrapped = (sum < -max_ext) ? (sum + (max_ext <<< 1)) : sum;
      end
      freq_next = PREC'(wrapped);
   end
endmodule

`default_nettype wire

// File: rtl/chirp_phase_gen.sv
// ---------------------------------------------------------------------------
// chirp_phase_gen : per-sample chirp phase accumulator, phase-continuous
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module chirp_phase_gen
   import chirp_phase_gen_pkg::*;
#(
   parameter int PREC  = PRECISION,
   parameter int CNT_W = SYMBOL_PRECISION
) (
   input  logic                   clk,
   input  logic                   rst_n,
   chirp_phase_gen_if.slave       chirp,
   input  logic                   sample_en,
   output logic signed [PREC-1:0] phase_out,
   output logic                   phase_valid,
   output logic                   chirp_last,
   output logic                   busy
);
   state_e                     state_q, state_d;
   logic [CHIRP_TYPE_SIZE-1:0] type_q, type_d;
   logic signed [PREC-1:0]     freq_q, freq_d;
   logic [PREC-1:0]            step_q, step_d;
   logic [PREC-1:0]            max_q, max_d;
   logic [CNT_W-1:0]           len_q, len_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic signed [PREC-1:0]     phase_acc_q, phase_acc_d;
   logic signed [PREC-1:0]     phase_out_q, phase_out_d;
   logic                       phase_valid_q, phase_valid_d;
   logic                       chirp_last_q, chirp_last_d;
   logic signed [PREC-1:0]     freq_next;

   chirp_freq_wrap #(.PREC(PREC)) u_freq_wrap (
      .chirp_type (type_q),
      .freq       (freq_q),
      .freq_step  (step_q),
      .freq_max   (max_q),
      .freq_next  (freq_next)
   );

   assign chirp.chirp_ready = (state_q == IDLE);
   assign busy              = (state_q != IDLE);
   assign phase_out         = phase_out_q;
   assign phase_valid       = phase_valid_q;
   assign chirp_last        = chirp_last_q;

   always_comb begin
      state_d       = state_q;
      type_d        = type_q;
      freq_d        = freq_q;
      step_d        = step_q;
      max_d         = max_q;
      len_d         = len_q;
      cnt_d         = cnt_q;
      phase_acc_d   = phase_acc_q;
      phase_out_d   = phase_out_q;
      phase_valid_d = 1'b0;
      chirp_last_d  = 1'b0;
      case (state_q)
         IDLE: begin
            // phase_acc is deliberately untouched so back-to-back chirps stay continuous.
            if (chirp.chirp_valid && (chirp.chirp_len != '0)) begin
               type_d  = chirp.chirp_type;
               freq_d  = chirp.freq_init;
               step_d  = chirp.freq_step;
               max_d   = chirp.freq_max;
               len_d   = chirp.chirp_len;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (sample_en) begin
               phase_out_d   = phase_acc_q;
               phase_valid_d = 1'b1;
               phase_acc_d   = phase_acc_q + freq_q;
               freq_d        = freq_next;
               if (cnt_q == len_q - CNT_W'(1)) begin
                  chirp_last_d = 1'b1;
                  cnt_d        = '0;
                  state_d      = IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         type_q        <= TYPE_UPCHIRP;
         freq_q        <= '0;
         step_q        <= '0;
         max_q         <= '0;
         len_q         <= '0;
         cnt_q         <= '0;
         phase_acc_q   <= '0;
         phase_out_q   <= '0;
         phase_valid_q <= 1'b0;
         chirp_last_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         type_q        <= type_d;
         freq_q        <= freq_d;
         step_q        <= step_d;
         max_q         <= max_d;
         len_q         <= len_d;
         cnt_q         <= cnt_d;
         phase_acc_q   <= phase_acc_d;
         phase_out_q   <= phase_out_d;
         phase_valid_q <= phase_valid_d;
         chirp_last_q  <= chirp_last_d;
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_chirp_phase_gen.sv
// ---------------------------------------------------------------------------
// tb_chirp_phase_gen : directed + randomized chirps against an arithmetic model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_chirp_phase_gen;
   import chirp_phase_gen_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              sample_en = 1'b0;
   logic signed [31:0] phase_out;
   logic              phase_valid;
   logic              chirp_last;
   logic              busy;

   int n_vec = 0;
   int n_err = 0;

   longint m_phase = 0;
   longint m_freq  = 0;

   chirp_phase_gen_if #(.PREC(32), .CNT_W(16)) cif ();

   chirp_phase_gen #(.PREC(32), .CNT_W(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .chirp       (cif),
      .sample_en   (sample_en),
      .phase_out   (phase_out),
      .phase_valid (phase_valid),
      .chirp_last  (chirp_last),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic longint wrap32(input longint x);
      logic [31:0] t;
      t = x[31:0];
      return $signed(t);
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      sample_en = 1'b0;
      cif.chirp_valid = 1'b0;
      #1;
      check("rst_phase", phase_out, 32'h0);
      check("rst_valid", phase_valid, 32'h0);
      check("rst_last", chirp_last, 32'h0);
      check("rst_busy", busy, 32'h0);
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
      check("rst_ready", cif.chirp_ready, 32'h1);
      m_phase = 0;
   endtask

   task automatic run_chirp(input bit down, input longint finit, input longint step,
                            input longint fmax, input int len, input int gap_min,
                            input int gap_max, input bit tick_on_accept, input int abort_at);
      int     guard;
      longint exp_out;
      longint fn;
      guard = 0;
      while (cif.chirp_ready !== 1'b1 && guard < 20) begin
         next_cycle();
         guard++;
      end
      if (guard >= 20) begin
         check("ready_timeout", cif.chirp_ready, 32'h1);
         return;
      end
      cif.chirp_valid = 1'b1;
      cif.chirp_type  = down ? TYPE_DOWNCHIRP : TYPE_UPCHIRP;
      cif.freq_init   = finit[31:0];
      cif.freq_step   = step[31:0];
      cif.freq_max    = fmax[31:0];
      cif.chirp_len   = len[15:0];
      sample_en       = tick_on_accept;
      next_cycle();
      cif.chirp_valid = 1'b0;
      sample_en       = 1'b0;
      cif.chirp_type  = 1'($urandom);
      cif.freq_init   = $urandom;
      cif.freq_step   = $urandom;
      cif.freq_max    = $urandom;
      cif.chirp_len   = 16'($urandom);
      check("accept_valid", phase_valid, 32'h0);
      if (len == 0) begin
         check("len0_ready", cif.chirp_ready, 32'h1);
         check("len0_busy", busy, 32'h0);
         sample_en = 1'b1;
         next_cycle();
         sample_en = 1'b0;
         check("len0_valid", phase_valid, 32'h0);
         return;
      end
      check("run_busy", busy, 32'h1);
      check("run_ready", cif.chirp_ready, 32'h0);
      m_freq = finit;
      for (int i = 0; i < len; i++) begin
         int gap;
         gap = $urandom_range(gap_min, gap_max);
         for (int g = 0; g < gap; g++) begin
            next_cycle();
            check("hold_valid", phase_valid, 32'h0);
            check("hold_busy", busy, 32'h1);
         end
         if (abort_at == i) begin
            rst_n = 1'b0;
            #1;
            check("abort_phase", phase_out, 32'h0);
            check("abort_valid", phase_valid, 32'h0);
            check("abort_last", chirp_last, 32'h0);
            check("abort_busy", busy, 32'h0);
            m_phase = 0;
            next_cycle();
            rst_n = 1'b1;
            next_cycle();
            check("abort_ready", cif.chirp_ready, 32'h1);
            check("abort_last2", chirp_last, 32'h0);
            return;
         end
         sample_en = 1'b1;
         next_cycle();
         sample_en = 1'b0;
         exp_out = wrap32(m_phase);
         m_phase = wrap32(m_phase + m_freq);
         if (!down) begin
            fn = m_freq + step;
            if (fn > fmax) fn = fn - 2 * fmax;
         end else begin
            fn = m_freq - step;
            if (fn < -fmax) fn = fn + 2 * fmax;
         end
         m_freq = fn;
         check("phase", phase_out, exp_out[31:0]);
         check("valid", phase_valid, 32'h1);
         check("last", chirp_last, (i == len - 1) ? 32'h1 : 32'h0);
      end
      check("end_ready", cif.chirp_ready, 32'h1);
      check("end_busy", busy, 32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit     down;
      longint fmax, step, finit;
      int     len, abort_at;
      cif.chirp_valid = 1'b0;
      cif.chirp_type  = TYPE_UPCHIRP;
      cif.freq_init   = '0;
      cif.freq_step   = '0;
      cif.freq_max    = '0;
      cif.chirp_len   = '0;
      do_reset();

      run_chirp(1'b0, -1000, 10, 1000, 4, 0, 0, 1'b0, -1);
      run_chirp(1'b0, 0, 1, 100, 2, 0, 0, 1'b0, -1);
      do_reset();
      run_chirp(1'b0, 995, 10, 1000, 3, 0, 0, 1'b0, -1);
      do_reset();
      run_chirp(1'b1, -995, 10, 1000, 3, 0, 0, 1'b0, -1);
      run_chirp(1'b0, 123, 7, 500, 2, 2, 2, 1'b0, -1);
      run_chirp(1'b1, 300, 25, 400, 6, 0, 1, 1'b0, 2);
      run_chirp(1'b0, 50, 5, 100, 0, 0, 0, 1'b0, -1);
      run_chirp(1'b1, 10, 3, 100, 3, 0, 1, 1'b1, -1);

      for (int k = 0; k < 40; k++) begin
         down = 1'($urandom);
         if ($urandom_range(0, 1) == 0) fmax = longint'($urandom_range(1, 2000));
         else                          fmax = longint'($urandom_range(1, 32'h7FFF_FFFF));
         step  = longint'($urandom_range(0, 32'(fmax)));
         finit = longint'($urandom_range(0, 32'(2 * fmax))) - fmax;
         len   = $urandom_range(0, 9);
         abort_at = -1;
         if (len > 0 && $urandom_range(0, 14) == 0) abort_at = $urandom_range(0, len - 1);
         run_chirp(down, finit, step, fmax, len, 0, 2, 1'($urandom), abort_at);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

`default_nettype wire
